// File: rtl/adder_error_monitor.sv
// Windowed error statistics (count, max and saturating sum of |exact - approx|) for an approximate adder.
// Defining ERR_BIAS_EN adds the bias_sum port: a signed saturating sum of (approx - exact).
module adder_error_monitor #(
    parameter int W            = 6,
    parameter int SAMPLES_LOG2 = 8,
    parameter int ACC_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W:0]              y_exact,
    input  logic [W:0]              y_approx,
    output logic                    busy,
    output logic                    done,
    output logic [SAMPLES_LOG2:0]   err_count,
    output logic [W:0]              max_ed,
    output logic [ACC_W-1:0]        sum_ed,
    output logic                    sum_sat
`ifdef ERR_BIAS_EN
    ,
    output logic signed [ACC_W-1:0] bias_sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = SAMPLES_LOG2 + 1;
    // One spare bit above the wider of the accumulator and the error distance, so an overflow is visible.
    localparam int SW = ((ACC_W > W + 1) ? ACC_W : W + 1) + 1;
    localparam logic [CW-1:0] LAST_IDX = {1'b0, {SAMPLES_LOG2{1'b1}}};
    localparam logic [SW-1:0] SUM_MAX  = SW'({ACC_W{1'b1}});

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   err_count_q, err_count_d;
    logic [W:0]      max_ed_q, max_ed_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
    logic            sum_sat_q, sum_sat_d;

    logic            accept;
    logic [W:0]      ed;
    logic [SW-1:0]   sum_wide;

    // A start in RUN takes priority over a sample offered in the same cycle; that sample is dropped.
    assign accept   = (state_q == S_RUN) && in_valid && !start;
    assign ed       = (y_exact >= y_approx) ? (y_exact - y_approx) : (y_approx - y_exact);
    assign sum_wide = SW'(sum_ed_q) + SW'(ed);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_count_d = err_count_q;
        max_ed_d    = max_ed_q;
        sum_ed_d    = sum_ed_q;
        sum_sat_d   = sum_sat_q;

        if (start) begin
            state_d     = S_RUN;
            cnt_d       = '0;
            err_count_d = '0;
            max_ed_d    = '0;
            sum_ed_d    = '0;
            sum_sat_d   = 1'b0;
        end else if (accept) begin
            cnt_d       = cnt_q + CW'(1);
            err_count_d = err_count_q + CW'(ed != '0);
            if (ed > max_ed_q) begin
                max_ed_d = ed;
            end
            if (sum_wide > SUM_MAX) begin
                sum_ed_d  = '1;
                sum_sat_d = 1'b1;
            end else begin
                sum_ed_d = sum_wide[ACC_W-1:0];
            end
            if (cnt_q == LAST_IDX) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_count_q <= '0;
            max_ed_q    <= '0;
            sum_ed_q    <= '0;
            sum_sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
            max_ed_q    <= max_ed_d;
            sum_ed_q    <= sum_ed_d;
            sum_sat_q   <= sum_sat_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign in_ready  = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign err_count = err_count_q;
    assign max_ed    = max_ed_q;
    assign sum_ed    = sum_ed_q;
    assign sum_sat   = sum_sat_q;

`ifdef ERR_BIAS_EN
    localparam int BW = ((ACC_W > W + 2) ? ACC_W : W + 2) + 1;
    localparam logic signed [BW-1:0] BIAS_MAX = {{(BW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
    localparam logic signed [BW-1:0] BIAS_MIN = {{(BW - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};

    logic signed [ACC_W-1:0] bias_q, bias_d;
    logic signed [W+1:0]     diff;
    logic signed [BW-1:0]    bias_wide;

    assign diff      = $signed({1'b0, y_approx}) - $signed({1'b0, y_exact});
    assign bias_wide = BW'(bias_q) + BW'(diff);

    always_comb begin
        bias_d = bias_q;
        if (start) begin
            bias_d = '0;
        end else if (accept) begin
            if (bias_wide > BIAS_MAX) begin
                bias_d = $signed(BIAS_MAX[ACC_W-1:0]);
            end else if (bias_wide < BIAS_MIN) begin
                bias_d = $signed(BIAS_MIN[ACC_W-1:0]);
            end else begin
                bias_d = $signed(bias_wide[ACC_W-1:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
        end else begin
            bias_q <= bias_d;
        end
    end

    assign bias_sum = bias_q;
`endif

endmodule
